// File: rtl/traffic_light_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
// Shared types and constants for the sensor-triggered traffic-light sequencer.
//   state_t   : 2-bit state encoding shared with the surrounding intersection
//               logic (IDLE=00, GREEN=01, YELLOW=10, RED=11)
//   lamps_t   : one-hot lamp drive bundle {red, yellow, green}
//   LAMPS_*   : lamp decode constants, one per state
//   cnt_width : dwell-counter width, $clog2 of the largest dwell, minimum 1
// -----------------------------------------------------------------------------
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_RED    = 2'b11
    } state_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamps_t;

    localparam lamps_t LAMPS_OFF    = 3'b000;
    localparam lamps_t LAMPS_GREEN  = 3'b001;
    localparam lamps_t LAMPS_YELLOW = 3'b010;
    localparam lamps_t LAMPS_RED    = 3'b100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input int max_cycles);
        return (max_cycles <= 1) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/traffic_light_dwell_timer.sv
// -----------------------------------------------------------------------------
// traffic_light_dwell_timer
// Cycle counter that measures how long the sequencer has dwelt in a state.
//   clk    in   system clock, rising-edge active
//   rst    in   asynchronous, active-high reset (count -> 0)
//   clear  in   synchronous clear; asserted by the FSM on every state entry
//   limit  in   last count value of the current state (dwell cycles - 1)
//   done   out  high while count == limit, i.e. in the final dwell cycle
// -----------------------------------------------------------------------------
module traffic_light_dwell_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == limit);

endmodule

// File: rtl/traffic_light.sv
// -----------------------------------------------------------------------------
// traffic_light
// Sensor-triggered sequencer: dark in IDLE until a vehicle is sensed, then one
// GREEN -> YELLOW -> RED round and back to IDLE (at least one IDLE cycle).
//   clk     in   system clock, rising-edge active
//   rst     in   asynchronous, active-high reset
//   sensor  in   vehicle-present request, only looked at in IDLE
//   state   out  encoded current state (traffic_light_pkg::state_t)
//   red     out  red lamp drive    (Moore, from state register only)
//   yellow  out  yellow lamp drive (Moore, from state register only)
//   green   out  green lamp drive  (Moore, from state register only)
// Build option:
//   TRAFFIC_LIGHT_SENSOR_SYNC_EN  when defined, sensor passes through a 2-flop
//   synchronizer first; IDLE->GREEN latency grows from 1 to 3 edges.
// -----------------------------------------------------------------------------
module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int GREEN_CYCLES  = 1,
    parameter int YELLOW_CYCLES = 1,
    parameter int RED_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    output logic [1:0] state,
    output logic       red,
    output logic       yellow,
    output logic       green
);

    localparam int CNT_W = cnt_width(max3(GREEN_CYCLES, YELLOW_CYCLES, RED_CYCLES));

    state_t           r_state;
    state_t           w_state_next;
    lamps_t           w_lamps;
    logic             w_sensor;
    logic             w_clear;
    logic             w_done;
    logic [CNT_W-1:0] w_limit;

`ifdef TRAFFIC_LIGHT_SENSOR_SYNC_EN
    logic r_sensor_meta;
    logic r_sensor_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sensor_meta <= 1'b0;
            r_sensor_sync <= 1'b0;
        end else begin
            r_sensor_meta <= sensor;
            r_sensor_sync <= r_sensor_meta;
        end
    end

    assign w_sensor = r_sensor_sync;
`else
    assign w_sensor = sensor;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_limit      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sensor) begin
                    w_state_next = ST_GREEN;
                end
            end
            ST_GREEN: begin
                w_limit = CNT_W'(GREEN_CYCLES - 1);
                if (w_done) begin
                    w_state_next = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                w_limit = CNT_W'(YELLOW_CYCLES - 1);
                if (w_done) begin
                    w_state_next = ST_RED;
                end
            end
            ST_RED: begin
                w_limit = CNT_W'(RED_CYCLES - 1);
                if (w_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Counter restarts on every state entry and is parked at zero in IDLE, so
    // the first cycle of each timed state always reads count == 0.
    assign w_clear = (w_state_next != r_state) || (r_state == ST_IDLE);

    traffic_light_dwell_timer #(
        .WIDTH (CNT_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .limit (w_limit),
        .done  (w_done)
    );

    always_comb begin
        w_lamps = LAMPS_OFF;
        case (r_state)
            ST_GREEN:  w_lamps = LAMPS_GREEN;
            ST_YELLOW: w_lamps = LAMPS_YELLOW;
            ST_RED:    w_lamps = LAMPS_RED;
            default:   w_lamps = LAMPS_OFF;
        endcase
    end

    assign state  = r_state;
    assign red    = w_lamps.red;
    assign yellow = w_lamps.yellow;
    assign green  = w_lamps.green;

endmodule

// File: tb/tb_traffic_light.sv
// -----------------------------------------------------------------------------
// tb_traffic_light
// Directed bench for traffic_light: a default-parameter instance (dut) and a
// 3/2/2 dwell instance (dut2) sharing clock and reset. Observed value per
// check is {state, red, yellow, green}. Adapts the expected IDLE->GREEN
// latency when TRAFFIC_LIGHT_SENSOR_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_traffic_light;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_GREEN  = 2'b01;
    localparam logic [1:0] S_YELLOW = 2'b10;
    localparam logic [1:0] S_RED    = 2'b11;

`ifdef TRAFFIC_LIGHT_SENSOR_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic       sensor;
    logic       sensor2;
    logic [1:0] state;
    logic       red;
    logic       yellow;
    logic       green;
    logic [1:0] state2;
    logic       red2;
    logic       yellow2;
    logic       green2;

    int n_checks;
    int n_errors;

    traffic_light dut (
        .clk    (clk),
        .rst    (rst),
        .sensor (sensor),
        .state  (state),
        .red    (red),
        .yellow (yellow),
        .green  (green)
    );

    traffic_light #(
        .GREEN_CYCLES  (3),
        .YELLOW_CYCLES (2),
        .RED_CYCLES    (2)
    ) dut2 (
        .clk    (clk),
        .rst    (rst),
        .sensor (sensor2),
        .state  (state2),
        .red    (red2),
        .yellow (yellow2),
        .green  (green2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state, red, yellow, green} for a given state encoding.
    function automatic logic [4:0] expect_of(input logic [1:0] s);
        case (s)
            S_GREEN:  return {s, 3'b001};
            S_YELLOW: return {s, 3'b010};
            S_RED:    return {s, 3'b100};
            default:  return {s, 3'b000};
        endcase
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got state=%b rgy_lamps(r,y,g)=%b, expected state=%b lamps=%b",
                     tag, got[4:3], got[2:0], exp[4:3], exp[2:0]);
        end
    endtask

    task automatic chk1(input string tag, input logic [1:0] s);
        check(tag, {state, red, yellow, green}, expect_of(s));
    endtask

    task automatic chk2(input string tag, input logic [1:0] s);
        check(tag, {state2, red2, yellow2, green2}, expect_of(s));
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        sensor   = 1'b0;
        sensor2  = 1'b0;

        // Reset held: IDLE, lamps dark, even across an edge with sensor high.
        #12;
        chk1("reset_hold", S_IDLE);
        chk2("reset_hold_dut2", S_IDLE);
        sensor = 1'b1;
        step();
        chk1("reset_ignores_sensor", S_IDLE);
        sensor = 1'b0;
        #3 rst = 1'b0;

        // Sensor low: stays dark.
        for (int i = 0; i < 2; i++) begin
            step();
            chk1($sformatf("idle_quiet_%0d", i), S_IDLE);
        end

        // Single sensor pulse: one full round.
        sensor = 1'b1;
        step();
        sensor = 1'b0;
        for (int i = 0; i < SYNC_LAT; i++) begin
            chk1($sformatf("pulse_sync_wait_%0d", i), S_IDLE);
            step();
        end
        chk1("pulse_green", S_GREEN);
        step();
        chk1("pulse_yellow", S_YELLOW);
        step();
        chk1("pulse_red", S_RED);
        step();
        chk1("pulse_idle", S_IDLE);
        step();
        chk1("pulse_idle_stays", S_IDLE);

        // Held sensor: exactly one IDLE cycle between rounds.
        sensor = 1'b1;
        step();
        for (int i = 0; i < SYNC_LAT; i++) begin
            chk1($sformatf("held_sync_wait_%0d", i), S_IDLE);
            step();
        end
        chk1("held_green", S_GREEN);
        step();
        chk1("held_yellow", S_YELLOW);
        step();
        chk1("held_red", S_RED);
        step();
        chk1("held_idle_gap", S_IDLE);
        step();
        chk1("held_green_again", S_GREEN);
        sensor = 1'b0;
        step();
        chk1("held_drain_yellow", S_YELLOW);
        step();
        chk1("held_drain_red", S_RED);
        step();
        chk1("held_drain_idle", S_IDLE);
        step();
        chk1("held_drain_idle_stays", S_IDLE);

        // Asynchronous reset in the middle of YELLOW.
        sensor = 1'b1;
        step();
        sensor = 1'b0;
        for (int i = 0; i < SYNC_LAT; i++) step();
        chk1("rst_mid_green", S_GREEN);
        step();
        chk1("rst_mid_yellow", S_YELLOW);
        #3 rst = 1'b1;
        #1;
        chk1("rst_async_immediate", S_IDLE);
        step();
        chk1("rst_async_held", S_IDLE);
        #3 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1($sformatf("rst_release_idle_%0d", i), S_IDLE);
        end

        // Longer dwells on dut2: 3 green, 2 yellow, 2 red; dut stays dark.
        sensor2 = 1'b1;
        step();
        sensor2 = 1'b0;
        for (int i = 0; i < SYNC_LAT; i++) step();
        for (int i = 0; i < 3; i++) begin
            chk2($sformatf("dwell_green_%0d", i), S_GREEN);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk2($sformatf("dwell_yellow_%0d", i), S_YELLOW);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk2($sformatf("dwell_red_%0d", i), S_RED);
            step();
        end
        chk2("dwell_idle", S_IDLE);
        chk1("dut_untouched", S_IDLE);

        // Reset after two GREEN cycles on dut2; the next round must again
        // spend a full three cycles in GREEN (counter cleared by reset).
        sensor2 = 1'b1;
        step();
        sensor2 = 1'b0;
        for (int i = 0; i < SYNC_LAT; i++) step();
        chk2("clr_green_0", S_GREEN);
        step();
        chk2("clr_green_1", S_GREEN);
        #3 rst = 1'b1;
        #1;
        chk2("clr_rst_idle", S_IDLE);
        #2 rst = 1'b0;
        sensor2 = 1'b1;
        step();
        sensor2 = 1'b0;
        for (int i = 0; i < SYNC_LAT; i++) step();
        for (int i = 0; i < 3; i++) begin
            chk2($sformatf("clr_regreen_%0d", i), S_GREEN);
            step();
        end
        chk2("clr_yellow_after", S_YELLOW);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
Sensor-triggered traffic-light sequencer.
- Idles dark until a vehicle sensor is asserted.
- Then runs one GREEN -> YELLOW -> RED cycle and returns to IDLE.
- Leaf control block. Exposes its encoded state and one-hot lamp drives to the surrounding intersection logic.

Parameters:
GREEN_CYCLES, 1, clock cycles spent in GREEN (>=1)
YELLOW_CYCLES, 1, clock cycles spent in YELLOW (>=1)
RED_CYCLES, 1, clock cycles spent in RED (>=1)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
sensor  input  1  vehicle-present request, sampled on rising clk
state  output  2  current state encoding
red  output  1  red lamp drive
yellow  output  1  yellow lamp drive
green  output  1  green lamp drive

Behaviour:
- One clock; reset is asynchronous and active-high.
- State encoding: IDLE=2'b00, GREEN=2'b01, YELLOW=2'b10, RED=2'b11.
- Reset (rst=1, async assert): state=IDLE, dwell counter=0, all lamps 0. This holds immediately and stays held while rst=1.
- Reset release is synchronous-safe: first transition occurs at the first rising clk with rst=0.
- Moore outputs, decoded from the state register only, never from sensor:
  - IDLE: red=0, yellow=0, green=0
  - GREEN: green=1, others 0
  - YELLOW: yellow=1, others 0
  - RED: red=1, others 0
- Exactly one lamp is high outside IDLE.
- Transitions on rising clk:
  - IDLE: sensor=1 -> GREEN next cycle; sensor=0 -> stay IDLE.
  - GREEN: after GREEN_CYCLES cycles in state -> YELLOW. sensor is ignored.
  - YELLOW: after YELLOW_CYCLES -> RED. sensor is ignored.
  - RED: after RED_CYCLES -> IDLE. sensor is ignored.
- Dwell counter:
  - Clears on every state entry and increments each cycle in a timed state.
  - Exit happens when count == N-1, where N is the state's *_CYCLES.
  - Width is $clog2 of the max parameter, minimum 1 bit.
- IDLE is always occupied for at least one cycle after RED, even if sensor is held high. A held sensor therefore yields a period of GREEN+YELLOW+RED+1 cycles (4 at defaults).
- Sensor latency: sensor high at edge k (from IDLE) -> state=GREEN after edge k.
- Reset mid-sequence: immediate return to IDLE with lamps off; the counter is cleared.
- Illegal/unreached encodings: none, since the 2-bit space is fully used. The default branch of the next-state logic goes to IDLE.

Optional Feature:
TRAFFIC_LIGHT_SENSOR_SYNC_EN
- Defined: sensor passes through a 2-flop synchronizer, reset to 0 by rst, before use in IDLE. IDLE->GREEN latency becomes 3 edges after sensor rises.
- Undefined: sensor is used directly, with 1-edge latency as above.

Decomposition:
- Package traffic_light_pkg holds:
  - the state typedef (2-bit enum IDLE/GREEN/YELLOW/RED with the encodings above)
  - lamp-decode constants.
- One sub-module, traffic_light_dwell_timer, holds the loadable/clearing cycle counter:
  - Inputs: clear, limit.
  - Output: done pulse.
- The top module holds the FSM and output decode.

Test Plan:
- Reset then sensor=0 for 2 cycles -> state=00, red/yellow/green=0/0/0 each cycle.
- sensor=1 one cycle from IDLE, then 0 -> state sequence 01,10,11,00 on consecutive edges. Lamps: green; yellow; red; all off.
- sensor held 1 across 5 edges from IDLE -> 01,10,11,00,01 (single IDLE cycle between rounds).
- Assert rst during YELLOW (mid-cycle, not on an edge) -> state=00 and lamps 0 immediately. Stays IDLE until sensor=1 after release.
- GREEN_CYCLES=3, YELLOW_CYCLES=2, RED_CYCLES=2, sensor pulse -> green 3 edges, yellow 2, red 2, then IDLE.
- TRAFFIC_LIGHT_SENSOR_SYNC_EN defined, sensor rises -> state=01 on the third edge, not before.
